// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction sequencer and its command issuer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: controller command codes, transaction state enum, handshake phase enum.
package i2c_pkg;

  // Command codes understood by the bit-level I2C master controller.
  localparam logic [2:0] CMD_START   = 3'b001;
  localparam logic [2:0] CMD_WR      = 3'b010;
  localparam logic [2:0] CMD_RD      = 3'b011;
  localparam logic [2:0] CMD_STOP    = 3'b100;
  localparam logic [2:0] CMD_RESTART = 3'b101;

  // One state per command of a register transaction, plus IDLE and DONE.
  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DEV_W,
    S_REG,
    S_WDATA,
    S_RESTART,
    S_DEV_R,
    S_RDATA,
    S_STOP,
    S_DONE
  } seq_state_t;

  // Per-command handshake with the controller's ready line.
  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_WAIT_LO,
    PH_WAIT_HI
  } phase_t;

endpackage

// File: rtl/i2c_cmd_issuer.sv
// Runs the ready/strobe handshake for one controller command at a time.
// Latency: strobe one cycle after go+ready; cmd_done is combinational on ready rising in WAIT_HI.
// Backpressure: holds in ISSUE while ready is low; waits are unbounded unless I2C_SEQ_TIMEOUT_EN is defined.
// Ports: clk/rst; go, cmd, din (request from sequencer); ready (controller);
//        ctl_cmd, ctl_wr, ctl_din (to controller); issue (strobe about to fire),
//        cmd_done (command complete), timeout (only with I2C_SEQ_TIMEOUT_EN).
module i2c_cmd_issuer
  import i2c_pkg::*;
`ifdef I2C_SEQ_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = 100000
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [2:0] cmd,
  input  logic [7:0] din,
  input  logic       ready,
  output logic [2:0] ctl_cmd,
  output logic       ctl_wr,
  output logic [7:0] ctl_din,
  output logic       issue,
  output logic       cmd_done
`ifdef I2C_SEQ_TIMEOUT_EN
  ,
  output logic       timeout
`endif
);

  phase_t phase_q, phase_d;
  logic   fire;
  logic   tmo_hit;

  // The sequencer holds go for as long as it sits in a command state, so the
  // issuer only needs to wait in ISSUE for the controller to become ready.
  assign fire  = (phase_q == PH_ISSUE) && go && ready;
  assign issue = fire;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          waiting;
  logic          advance;

  assign waiting = (phase_q == PH_WAIT_LO) || (phase_q == PH_WAIT_HI);
  assign advance = ((phase_q == PH_WAIT_LO) && !ready) ||
                   ((phase_q == PH_WAIT_HI) &&  ready);
  // tmo_cnt_q counts the cycles already spent in the current wait phase, so the
  // hit lands on the TIMEOUT_CYC-th cycle of a stalled phase.
  assign tmo_hit = waiting && !advance && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign timeout = tmo_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (!waiting || advance || tmo_hit) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_ISSUE;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    cmd_done = 1'b0;
    case (phase_q)
      PH_ISSUE:   if (fire) phase_d = PH_WAIT_LO;
      PH_WAIT_LO: if (!ready) phase_d = PH_WAIT_HI;
      PH_WAIT_HI: begin
        if (ready) begin
          phase_d  = PH_ISSUE;
          cmd_done = 1'b1;
        end
      end
      default:    phase_d = PH_ISSUE;
    endcase
    if (tmo_hit) begin
      phase_d = PH_ISSUE;
    end
  end

  // Command and data are captured at the strobe and held until the next one,
  // so they stay stable for the whole handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_cmd <= 3'b000;
      ctl_din <= 8'h00;
      ctl_wr  <= 1'b0;
    end else begin
      ctl_wr <= fire;
      if (fire) begin
        ctl_cmd <= cmd;
        ctl_din <= din;
      end
    end
  end

endmodule

// File: rtl/i2c_transaction_sequencer.sv
// Drives a bit-level I2C master through complete register read/write transactions.
// Latency: busy the cycle after request accept; done one cycle after STOP completes.
// Backpressure: each command waits on controller ready; requests are ignored unless idle.
// Ports: i_clk/i_reset; host request (i_req, i_rw, i_dev_addr, i_reg_addr, i_len);
//        write data (i_wdata, o_wdata_req); read data (o_rdata, o_rdata_valid);
//        status (o_busy, o_done, o_nack_err); controller side (o_cmd, o_wr_i2c,
//        o_din, i_ready, i_dout, i_ack). Define I2C_SEQ_TIMEOUT_EN for the
//        ready-wait timeout (TIMEOUT_CYC parameter, o_timeout_err port).
module i2c_transaction_sequencer
  import i2c_pkg::*;
#(
  parameter int LEN_W = 4
`ifdef I2C_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 100000
`endif
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req,
  input  logic             i_rw,
  input  logic [6:0]       i_dev_addr,
  input  logic [7:0]       i_reg_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_wdata,
  output logic             o_wdata_req,
  output logic [7:0]       o_rdata,
  output logic             o_rdata_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_nack_err,
  output logic [2:0]       o_cmd,
  output logic             o_wr_i2c,
  output logic [7:0]       o_din,
  input  logic             i_ready,
  input  logic [7:0]       i_dout,
  input  logic             i_ack
`ifdef I2C_SEQ_TIMEOUT_EN
  ,
  output logic             o_timeout_err
`endif
);

  seq_state_t       state_q, state_d;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q;
  logic             rw_q;
  logic [LEN_W-1:0] cnt_q;
  logic             nack_q;

  logic             go;
  logic [2:0]       cmd_sel;
  logic [7:0]       din_sel;
  logic             issue;
  logic             cmd_done;
  logic             tmo;
  logic             accept;
  logic             last_byte;
  logic             wr_phase;
  logic             nack_hit;

  assign accept    = (state_q == S_IDLE) && i_req;
  assign last_byte = (cnt_q == LEN_W'(1));
  // Commands after which the slave's ACK bit is meaningful.
  assign wr_phase  = (state_q == S_DEV_W) || (state_q == S_REG) ||
                     (state_q == S_WDATA) || (state_q == S_DEV_R);
  assign nack_hit  = cmd_done && wr_phase && !i_ack;

  i2c_cmd_issuer
`ifdef I2C_SEQ_TIMEOUT_EN
    #(.TIMEOUT_CYC(TIMEOUT_CYC))
`endif
    u_issuer (
      .clk      (i_clk),
      .rst      (i_reset),
      .go       (go),
      .cmd      (cmd_sel),
      .din      (din_sel),
      .ready    (i_ready),
      .ctl_cmd  (o_cmd),
      .ctl_wr   (o_wr_i2c),
      .ctl_din  (o_din),
      .issue    (issue),
      .cmd_done (cmd_done)
`ifdef I2C_SEQ_TIMEOUT_EN
      ,
      .timeout  (tmo)
`endif
    );

`ifndef I2C_SEQ_TIMEOUT_EN
  assign tmo = 1'b0;
`endif

  // Command for the current state. i_wdata is passed straight through; the
  // issuer captures it on the same edge that ends the o_wdata_req pulse.
  always_comb begin
    go      = 1'b1;
    cmd_sel = CMD_START;
    din_sel = 8'h00;
    case (state_q)
      S_START:   cmd_sel = CMD_START;
      S_DEV_W: begin
        cmd_sel = CMD_WR;
        din_sel = {dev_q, 1'b0};
      end
      S_REG: begin
        cmd_sel = CMD_WR;
        din_sel = reg_q;
      end
      S_WDATA: begin
        cmd_sel = CMD_WR;
        din_sel = i_wdata;
      end
      S_RESTART: cmd_sel = CMD_RESTART;
      S_DEV_R: begin
        cmd_sel = CMD_WR;
        din_sel = {dev_q, 1'b1};
      end
      S_RDATA: begin
        cmd_sel = CMD_RD;
        din_sel = {7'b0, last_byte}; // master NACK on the final byte
      end
      S_STOP:    cmd_sel = CMD_STOP;
      default:   go = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_req) state_d = S_START;
      S_DONE: state_d = S_IDLE;
      default: begin
        if (tmo) begin
          state_d = S_DONE;               // abandon without STOP
        end else if (nack_hit) begin
          state_d = S_STOP;
        end else if (cmd_done) begin
          case (state_q)
            S_START:   state_d = S_DEV_W;
            S_DEV_W:   state_d = S_REG;
            S_REG: begin
              if (rw_q)              state_d = S_RESTART;
              else if (cnt_q == '0)  state_d = S_STOP;
              else                   state_d = S_WDATA;
            end
            S_WDATA:   state_d = last_byte ? S_STOP : S_WDATA;
            S_RESTART: state_d = S_DEV_R;
            S_DEV_R:   state_d = S_RDATA;
            S_RDATA:   state_d = last_byte ? S_STOP : S_RDATA;
            S_STOP:    state_d = S_DONE;
            default:   state_d = state_q;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dev_q         <= 7'h00;
      reg_q         <= 8'h00;
      rw_q          <= 1'b0;
      cnt_q         <= '0;
      nack_q        <= 1'b0;
      o_rdata       <= 8'h00;
      o_rdata_valid <= 1'b0;
    end else begin
      o_rdata_valid <= 1'b0;
      if (accept) begin
        dev_q  <= i_dev_addr;
        reg_q  <= i_reg_addr;
        rw_q   <= i_rw;
        // A zero-length read still fetches one byte.
        cnt_q  <= (i_rw && (i_len == '0)) ? LEN_W'(1) : i_len;
        nack_q <= 1'b0;
      end
      if (nack_hit) begin
        nack_q <= 1'b1;
      end
      if (cmd_done && !nack_hit &&
          ((state_q == S_WDATA) || (state_q == S_RDATA))) begin
        cnt_q <= cnt_q - LEN_W'(1);
      end
      if (cmd_done && (state_q == S_RDATA)) begin
        o_rdata       <= i_dout;
        o_rdata_valid <= 1'b1;
      end
    end
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  logic tmo_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_q <= 1'b0;
    end else if (accept) begin
      tmo_q <= 1'b0;
    end else if (tmo) begin
      tmo_q <= 1'b1;
    end
  end

  assign o_timeout_err = o_done && tmo_q;
`endif

  assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done      = (state_q == S_DONE);
  assign o_nack_err  = o_done && nack_q;
  assign o_wdata_req = issue && (state_q == S_WDATA);

endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
module tb_i2c_transaction_sequencer;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_req;
  logic       i_rw;
  logic [6:0] i_dev_addr;
  logic [7:0] i_reg_addr;
  logic [3:0] i_len;
  logic [7:0] i_wdata;
  logic       o_wdata_req;
  logic [7:0] o_rdata;
  logic       o_rdata_valid;
  logic       o_busy;
  logic       o_done;
  logic       o_nack_err;
  logic [2:0] o_cmd;
  logic       o_wr_i2c;
  logic [7:0] o_din;
  logic       i_ready;
  logic [7:0] i_dout;
  logic       i_ack;
`ifdef I2C_SEQ_TIMEOUT_EN
  logic       o_timeout_err;
`endif

  always #5 clk = ~clk;

  i2c_transaction_sequencer dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_req         (i_req),
    .i_rw          (i_rw),
    .i_dev_addr    (i_dev_addr),
    .i_reg_addr    (i_reg_addr),
    .i_len         (i_len),
    .i_wdata       (i_wdata),
    .o_wdata_req   (o_wdata_req),
    .o_rdata       (o_rdata),
    .o_rdata_valid (o_rdata_valid),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_nack_err    (o_nack_err),
    .o_cmd         (o_cmd),
    .o_wr_i2c      (o_wr_i2c),
    .o_din         (o_din),
    .i_ready       (i_ready),
    .i_dout        (i_dout),
    .i_ack         (i_ack)
`ifdef I2C_SEQ_TIMEOUT_EN
    ,
    .o_timeout_err (o_timeout_err)
`endif
  );

  localparam logic [2:0] C_START = 3'b001, C_WR = 3'b010, C_RD = 3'b011,
                         C_STOP  = 3'b100, C_RESTART = 3'b101;

  int tests = 0;
  int fails = 0;

  // Controller model state and monitor records (written only by the model).
  logic [2:0] log_cmd [0:63];
  logic [7:0] log_din [0:63];
  int         ncmd = 0;
  int         rd_issued = 0;
  logic [7:0] rd_seen [0:15];
  int         rdv_cnt = 0;
  int         wreq_cnt = 0;
  int         done_cnt = 0;
  logic       nack_at_done = 1'b0;
  logic       busy_at_done = 1'b0;
  int         dly = 0;

  // Stimulus tables (written only by the main sequence).
  logic [7:0] rd_vals [0:15];
  logic [7:0] wlist [0:7];
  int         nack_at = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [2:0] c, input logic [7:0] d);
    check(tag, {21'b0, log_cmd[idx], log_din[idx]}, {21'b0, c, d});
  endtask

  task automatic chk_cmd(input string tag, input int idx, input logic [2:0] c);
    check(tag, {29'b0, log_cmd[idx]}, {29'b0, c});
  endtask

  task automatic request(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [3:0] len);
    i_rw       = rw;
    i_dev_addr = dev;
    i_reg_addr = rg;
    i_len      = len;
    i_req      = 1'b1;
    @(negedge clk);
    i_req      = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("done_reached", {31'b0, done_cnt >= target}, 32'd1);
  endtask

  // Controller model: acknowledges each strobe by dropping ready for a few
  // cycles, supplies ACK/read data, and records what the DUT emitted.
  initial begin
    i_ready = 1'b1;
    i_ack   = 1'b1;
    i_dout  = 8'h00;
    i_wdata = 8'h00;
    forever begin
      @(negedge clk);
      i_wdata = wlist[wreq_cnt % 8];
      if (o_wdata_req) wreq_cnt++;
      if (o_rdata_valid) begin
        rd_seen[rdv_cnt % 16] = o_rdata;
        rdv_cnt++;
      end
      if (o_done) begin
        done_cnt++;
        nack_at_done = o_nack_err;
        busy_at_done = o_busy;
      end
      if (i_reset) begin
        i_ready = 1'b1;
        dly     = 0;
      end else if (o_wr_i2c) begin
        log_cmd[ncmd % 64] = o_cmd;
        log_din[ncmd % 64] = o_din;
        if (o_cmd == C_RD) begin
          i_dout = rd_vals[rd_issued % 16];
          rd_issued++;
        end
        i_ack   = (ncmd != nack_at);
        ncmd++;
        i_ready = 1'b0;
        dly     = 2;
      end else if (!i_ready) begin
        if (dly > 0) dly--;
        else i_ready = 1'b1;
      end
    end
  end

  initial begin
    int base, wbase, rbase, d, n;
    for (int i = 0; i < 16; i++) rd_vals[i] = 8'h5A;
    for (int i = 0; i < 8; i++) wlist[i] = 8'h00;
    wlist[0]   = 8'hAA;
    wlist[1]   = 8'h55;
    rd_vals[0] = 8'h11;
    rd_vals[1] = 8'h22;
    rd_vals[2] = 8'h33;
    i_reset = 1'b1;
    i_req = 1'b0; i_rw = 1'b0; i_dev_addr = 7'h00; i_reg_addr = 8'h00; i_len = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_done", {31'b0, o_done}, 32'd0);
    check("rst_wr_i2c", {31'b0, o_wr_i2c}, 32'd0);
    check("rst_cmd_din", {21'b0, o_cmd, o_din}, 32'd0);
    check("rst_rdata", {23'b0, o_rdata_valid, o_rdata}, 32'd0);
    check("rst_flags", {30'b0, o_wdata_req, o_nack_err}, 32'd0);
    i_reset = 1'b0;
    @(negedge clk);

    // Write dev 0x50 reg 0x10, two bytes, all ACKed.
    base = ncmd; wbase = wreq_cnt; d = done_cnt;
    request(1'b0, 7'h50, 8'h10, 4'd2);
    check("wr_busy_after_accept", {31'b0, o_busy}, 32'd1);
    wait_done(d + 1);
    check("wr_ncmd", ncmd - base, 32'd6);
    chk_cmd("wr_c0_start", base, C_START);
    chk_log("wr_c1_dev", base + 1, C_WR, 8'hA0);
    chk_log("wr_c2_reg", base + 2, C_WR, 8'h10);
    chk_log("wr_c3_d0", base + 3, C_WR, 8'hAA);
    chk_log("wr_c4_d1", base + 4, C_WR, 8'h55);
    chk_cmd("wr_c5_stop", base + 5, C_STOP);
    check("wr_wdata_reqs", wreq_cnt - wbase, 32'd2);
    check("wr_nack_err", {31'b0, nack_at_done}, 32'd0);
    check("wr_busy_at_done", {31'b0, busy_at_done}, 32'd0);

    // Read dev 0x50 reg 0x00, three bytes.
    base = ncmd; rbase = rdv_cnt; d = done_cnt;
    request(1'b1, 7'h50, 8'h00, 4'd3);
    wait_done(d + 1);
    check("rd_ncmd", ncmd - base, 32'd9);
    chk_cmd("rd_c0_start", base, C_START);
    chk_log("rd_c1_dev", base + 1, C_WR, 8'hA0);
    chk_log("rd_c2_reg", base + 2, C_WR, 8'h00);
    chk_cmd("rd_c3_restart", base + 3, C_RESTART);
    chk_log("rd_c4_devr", base + 4, C_WR, 8'hA1);
    chk_log("rd_c5_rd", base + 5, C_RD, 8'h00);
    chk_log("rd_c6_rd", base + 6, C_RD, 8'h00);
    chk_log("rd_c7_rdlast", base + 7, C_RD, 8'h01);
    chk_cmd("rd_c8_stop", base + 8, C_STOP);
    check("rd_valid_count", rdv_cnt - rbase, 32'd3);
    check("rd_byte0", {24'b0, rd_seen[rbase % 16]}, 32'h11);
    check("rd_byte1", {24'b0, rd_seen[(rbase + 1) % 16]}, 32'h22);
    check("rd_byte2", {24'b0, rd_seen[(rbase + 2) % 16]}, 32'h33);

    // Write len 3, slave NACKs the device address.
    base = ncmd; wbase = wreq_cnt; d = done_cnt;
    nack_at = base + 1;
    request(1'b0, 7'h50, 8'h10, 4'd3);
    wait_done(d + 1);
    nack_at = -1;
    check("nack_ncmd", ncmd - base, 32'd3);
    chk_cmd("nack_c2_stop", base + 2, C_STOP);
    check("nack_wdata_reqs", wreq_cnt - wbase, 32'd0);
    check("nack_err", {31'b0, nack_at_done}, 32'd1);

    // Pointer-set write (len 0) with a second request while busy.
    base = ncmd; d = done_cnt;
    request(1'b0, 7'h3C, 8'h7E, 4'd0);
    repeat (3) @(negedge clk);
    i_rw = 1'b1; i_len = 4'd5; i_req = 1'b1;
    @(negedge clk);
    i_req = 1'b0;
    wait_done(d + 1);
    repeat (30) @(negedge clk);
    check("len0_done_count", done_cnt - d, 32'd1);
    check("len0_ncmd", ncmd - base, 32'd4);
    chk_log("len0_c1_dev", base + 1, C_WR, 8'h78);
    chk_log("len0_c2_reg", base + 2, C_WR, 8'h7E);
    chk_cmd("len0_c3_stop", base + 3, C_STOP);
    check("len0_nack_cleared", {31'b0, nack_at_done}, 32'd0);
    check("len0_idle_busy", {31'b0, o_busy}, 32'd0);

    // Reset in the middle of a read.
    rbase = rdv_cnt;
    request(1'b1, 7'h50, 8'h20, 4'd3);
    n = 0;
    while (rdv_cnt == rbase && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_rd_reached", {31'b0, rdv_cnt > rbase}, 32'd1);
    i_reset = 1'b1;
    #1;
    check("arst_busy", {31'b0, o_busy}, 32'd0);
    check("arst_wr_i2c", {31'b0, o_wr_i2c}, 32'd0);
    check("arst_cmd_din", {21'b0, o_cmd, o_din}, 32'd0);
    check("arst_rdata", {23'b0, o_rdata_valid, o_rdata}, 32'd0);
    check("arst_done", {30'b0, o_done, o_wdata_req}, 32'd0);
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);

    // Zero-length read after reset behaves as a one-byte read.
    base = ncmd; rbase = rdv_cnt; d = done_cnt;
    request(1'b1, 7'h21, 8'h05, 4'd0);
    wait_done(d + 1);
    check("rd0_ncmd", ncmd - base, 32'd7);
    chk_log("rd0_c1_dev", base + 1, C_WR, 8'h42);
    chk_log("rd0_c4_devr", base + 4, C_WR, 8'h43);
    chk_log("rd0_c5_rdlast", base + 5, C_RD, 8'h01);
    chk_cmd("rd0_c6_stop", base + 6, C_STOP);
    check("rd0_valid_count", rdv_cnt - rbase, 32'd1);
    check("rd0_byte", {24'b0, rd_seen[rbase % 16]}, 32'h5A);
    check("rd0_nack_err", {31'b0, nack_at_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
